io_handshake_ctrl: RTL and testbench

Front-panel I/O controller for picoMIPS. It sequences the user-input handshake between the board switches (sw8 strobe, sws data) and the processor's input instruction. It stalls the core until a debounced sw8 press delivers a sampled sws value. It also owns the display output register. The block sits between the top-level pins and the picoMIPS datapath.

---
 rtl/io_handshake_ctrl.sv | 125 ++++++++++++
 tb/tb_io_handshake_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/io_handshake_ctrl.sv
// io_handshake_ctrl: picoMIPS front-panel input handshake and display register.
// Debounces the sw8 strobe, samples sws on acceptance and stalls the core meanwhile.
module io_handshake_ctrl #(
    parameter int N         = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sw8,
    input  logic [N-1:0] sws,
    input  logic         in_req,
    output logic         in_ack,
    output logic [N-1:0] in_data,
    output logic         stall,
    input  logic         out_we,
    input  logic [N-1:0] out_data,
    output logic [N-1:0] display
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        DELIVER      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_db_cnt;
    logic          r_sw8_meta;
    logic          r_sw8_s;
    logic [N-1:0]  r_sws_meta;
    logic [N-1:0]  r_sws_s;
    logic          r_in_ack;
    logic [N-1:0]  r_in_data;
    logic [N-1:0]  r_display;
    logic          w_db_done;

    assign w_db_done = (r_db_cnt == DB_LAST);

    // Two-flop synchronizers; nothing downstream looks at the raw pins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw8_meta <= 1'b0;
            r_sw8_s    <= 1'b0;
            r_sws_meta <= '0;
            r_sws_s    <= '0;
        end else begin
            r_sw8_meta <= sw8;
            r_sw8_s    <= r_sw8_meta;
            r_sws_meta <= sws;
            r_sws_s    <= r_sws_meta;
        end
    end

    // Handshake FSM with debounce counter and registered ack / data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_db_cnt  <= '0;
            r_in_ack  <= 1'b0;
            r_in_data <= '0;
        end else begin
            r_in_ack <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_db_cnt <= '0;
                    if (in_req) begin
                        r_state <= WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    if (!in_req) begin
                        r_state  <= IDLE;
                        r_db_cnt <= '0;
                    end else if (!r_sw8_s) begin
                        r_db_cnt <= '0;
                    end else if (!w_db_done) begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end else begin
                        r_in_data <= r_sws_s;
                        r_in_ack  <= 1'b1;
                        r_db_cnt  <= '0;
                        r_state   <= DELIVER;
                    end
                end
                DELIVER: begin
                    r_db_cnt <= '0;
                    r_state  <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (r_sw8_s) begin
                        r_db_cnt <= '0;
                    end else if (w_db_done) begin
                        r_db_cnt <= '0;
                        r_state  <= IDLE;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: begin
                    r_db_cnt <= '0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    // Display register, written by the core independently of the handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_display <= '0;
        end else if (out_we) begin
            r_display <= out_data;
        end
    end

    assign in_ack  = r_in_ack;
    assign in_data = r_in_data;
    assign display = r_display;
    assign stall   = in_req & ~r_in_ack;

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Bench for io_handshake_ctrl: directed stimulus, expected acks queued
// with data and cycle, popped and checked by a separate negedge monitor.
module tb_io_handshake_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw8;
    logic [7:0] sws;
    logic       in_req;
    logic       in_ack;
    logic [7:0] in_data;
    logic       stall;
    logic       out_we;
    logic [7:0] out_data;
    logic [7:0] display;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_test = 0;
    int   n_fail = 0;

    io_handshake_ctrl #(.N(8), .DB_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw8      (sw8),
        .sws      (sws),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .in_data  (in_data),
        .stall    (stall),
        .out_we   (out_we),
        .out_data (out_data),
        .display  (display)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_test++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ack(input logic [7:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every ack must match the oldest queued expectation
    always @(negedge clk) begin
        if (!reset && in_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ack_data", int'(in_data), int'(e.data));
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_stall", int'(stall), 0);
            end
        end
    end

    int c0;

    initial begin
        reset    = 1'b1;
        sw8      = 1'b1;
        sws      = 8'hFF;
        in_req   = 1'b1;
        out_we   = 1'b0;
        out_data = 8'h00;
        step(2);
        reset  = 1'b0;
        sw8    = 1'b0;
        in_req = 1'b0;
        chk("rst_ack", int'(in_ack), 0);
        chk("rst_data", int'(in_data), 0);
        chk("rst_disp", int'(display), 0);
        step(2);
        chk("rst_idle_ack", int'(in_ack), 0);

        // Basic input
        c0     = cyc;
        in_req = 1'b1;
        sws    = 8'h02;
        sw8    = 1'b1;
        expect_ack(8'h02, c0 + 6);
        step(5);
        chk("basic_stall_pre", int'(stall), 1);
        step(2);
        in_req = 1'b0;
        step(3);
        sw8 = 1'b0;
        step(8);
        chk("basic_data_hold", int'(in_data), 8'h02);

        // Glitch rejection
        in_req = 1'b1;
        sws    = 8'h5A;
        sw8    = 1'b1;
        step(3);
        sw8 = 1'b0;
        step(1);
        c0  = cyc;
        sw8 = 1'b1;
        expect_ack(8'h5A, c0 + 6);
        step(5);
        chk("glitch_no_early", int'(in_data), 8'h02);
        step(1);
        step(1);
        in_req = 1'b0;
        sw8    = 1'b0;
        step(8);

        // Held press yields one value; in_req stays high throughout
        c0     = cyc;
        in_req = 1'b1;
        sws    = 8'h07;
        sw8    = 1'b1;
        expect_ack(8'h07, c0 + 6);
        step(10);
        sws = 8'h03;
        step(10);
        chk("hold_stall", int'(stall), 1);
        chk("hold_data", int'(in_data), 8'h07);
        step(20);
        sw8 = 1'b0;
        step(3);
        chk("release_stall", int'(stall), 1);
        step(5);
        c0  = cyc;
        sw8 = 1'b1;
        expect_ack(8'h03, c0 + 6);
        step(7);
        in_req = 1'b0;
        step(4);
        sw8 = 1'b0;
        step(8);
        chk("hold_data2", int'(in_data), 8'h03);

        // Display write during WAIT_PRESS
        in_req = 1'b1;
        step(2);
        out_we   = 1'b1;
        out_data = 8'h2A;
        chk("disp_before", int'(display), 0);
        step(1);
        chk("disp_write", int'(display), 8'h2A);
        out_we   = 1'b0;
        out_data = 8'h55;
        step(3);
        chk("disp_hold", int'(display), 8'h2A);
        chk("disp_in_data", int'(in_data), 8'h03);
        chk("disp_stall", int'(stall), 1);
        in_req = 1'b0;
        step(2);

        // Reset during the third sw8_s-high cycle
        in_req = 1'b1;
        sws    = 8'h77;
        sw8    = 1'b1;
        step(4);
        reset  = 1'b1;
        in_req = 1'b0;
        sw8    = 1'b0;
        step(1);
        reset = 1'b0;
        chk("mid_rst_data", int'(in_data), 0);
        chk("mid_rst_disp", int'(display), 0);
        chk("mid_rst_ack", int'(in_ack), 0);
        step(10);
        in_req = 1'b1;
        step(1);
        chk("mid_rst_stall", int'(stall), 1);
        step(10);
        chk("mid_rst_data2", int'(in_data), 0);
        in_req = 1'b0;
        step(2);

        chk("missing_acks", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
